// File: rtl/serdes_sipo_piso_if.sv
// -----------------------------------------------------------------------------
// serdes_sipo_piso_if
// Groups the serial stream handshakes of the SIPO/PISO re-framer.
//
// Signals:
//   d_in     producer -> block  serial input data bit
//   valid_i  producer -> block  d_in is valid this cycle
//   ready_o  block -> producer  block accepts d_in this cycle
//   d_out    block -> consumer  serial output data bit
//   valid_o  block -> consumer  d_out is valid this cycle
//   ready_i  consumer -> block  consumer accepts d_out this cycle
//
// Modports:
//   slave   the re-framer itself (samples the input stream and ready_i,
//           drives ready_o and the output stream)
//   master  the environment around it (serial producer plus consumer)
// -----------------------------------------------------------------------------
interface serdes_sipo_piso_if;

    logic d_in;
    logic valid_i;
    logic ready_o;
    logic d_out;
    logic valid_o;
    logic ready_i;

    modport slave (
        input  d_in,
        input  valid_i,
        input  ready_i,
        output ready_o,
        output d_out,
        output valid_o
    );

    modport master (
        output d_in,
        output valid_i,
        output ready_i,
        input  ready_o,
        input  d_out,
        input  valid_o
    );

endinterface

// File: rtl/serdes_sipo_piso.sv
// -----------------------------------------------------------------------------
// serdes_sipo_piso
// Single-clock serial re-framer. Incoming bits are gathered LSB-first into a
// WIDTH-bit word (SIPO). A finished word is parked in a one-word hold
// register. From there it is re-serialised LSB-first (PISO). The output bit
// stream equals the input bit stream. It is only delayed and subject to
// backpressure.
//
// Ports:
//   sclk_i  clock; all state updates on the rising edge
//   rst_i   synchronous, active-high reset
//   sio     stream interface (slave modport):
//             d_in/valid_i/ready_o  input stream, ready_o is combinational
//             d_out/valid_o/ready_i output stream, valid_o is a flop,
//                                   d_out is a flopped bit gated by valid_o
// -----------------------------------------------------------------------------
module serdes_sipo_piso #(
    parameter int WIDTH = 8
) (
    input  logic                     sclk_i,
    input  logic                     rst_i,
    serdes_sipo_piso_if.slave        sio
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] sipo_q,      sipo_d;
    logic [CW-1:0]    in_cnt_q,    in_cnt_d;
    logic [WIDTH-1:0] hold_q,      hold_d;
    logic             hold_full_q, hold_full_d;
    logic [WIDTH-1:0] piso_q,      piso_d;
    logic [CW-1:0]    out_cnt_q,   out_cnt_d;
    logic             piso_busy_q, piso_busy_d;

    // ------------------------------------------------------------------
    // Handshake / control terms
    // ------------------------------------------------------------------
    logic in_last_s;     // next accepted bit completes a word
    logic out_last_s;    // bit on d_out is the last of its word
    logic out_xfer_s;    // output transfer at this edge
    logic load_s;        // hold -> PISO copy at this edge
    logic ready_s;       // input side can accept
    logic in_acc_s;      // input accept at this edge
    logic word_done_s;   // accept that completes a word

    // Handshake decode. The hold register drains either into an idle PISO
    // or into one whose last bit is leaving this very edge. That second
    // case gives seamless back-to-back words. ready_o only drops for the
    // final bit of a word, and only while the hold register still has no
    // place to go.
    always_comb begin
        in_last_s   = (in_cnt_q == LAST_IDX);
        out_last_s  = (out_cnt_q == LAST_IDX);
        out_xfer_s  = piso_busy_q && sio.ready_i;
        load_s      = hold_full_q && (!piso_busy_q || (out_last_s && out_xfer_s));
        ready_s     = !(in_last_s && hold_full_q && !load_s);
        in_acc_s    = sio.valid_i && ready_s;
        word_done_s = in_acc_s && in_last_s;
    end

    // SIPO next state: bit k of a word lands at position k, so arrival
    // order maps to LSB-first storage.
    always_comb begin
        sipo_d   = sipo_q;
        in_cnt_d = in_cnt_q;
        if (in_acc_s) begin
            sipo_d[in_cnt_q] = sio.d_in;
            if (in_last_s) begin
                in_cnt_d = CNT_ZERO;
            end else begin
                in_cnt_d = in_cnt_q + CNT_ONE;
            end
        end else begin
            sipo_d   = sipo_q;
            in_cnt_d = in_cnt_q;
        end
    end

    // Hold register next state. A word completing on the same edge as a
    // load re-fills the register, so "set" takes priority over "clear".
    // sipo_d already carries the bit being accepted now, which makes the
    // captured word complete.
    always_comb begin
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        if (word_done_s) begin
            hold_d      = sipo_d;
            hold_full_d = 1'b1;
        end else if (load_s) begin
            hold_d      = hold_q;
            hold_full_d = 1'b0;
        end else begin
            hold_d      = hold_q;
            hold_full_d = hold_full_q;
        end
    end

    // PISO next state. A load always wins over the shift. A load can only
    // coincide with a transfer when that transfer is the final bit of the
    // current word, so no valid bit is overwritten.
    always_comb begin
        piso_d      = piso_q;
        out_cnt_d   = out_cnt_q;
        piso_busy_d = piso_busy_q;
        if (load_s) begin
            piso_d      = hold_q;
            out_cnt_d   = CNT_ZERO;
            piso_busy_d = 1'b1;
        end else if (out_xfer_s) begin
            piso_d = {1'b0, piso_q[WIDTH-1:1]};
            if (out_last_s) begin
                out_cnt_d   = CNT_ZERO;
                piso_busy_d = 1'b0;
            end else begin
                out_cnt_d   = out_cnt_q + CNT_ONE;
                piso_busy_d = 1'b1;
            end
        end else begin
            piso_d      = piso_q;
            out_cnt_d   = out_cnt_q;
            piso_busy_d = piso_busy_q;
        end
    end

    // State register with synchronous reset. A reset drops any partial and
    // buffered words.
    always_ff @(posedge sclk_i) begin
        if (rst_i) begin
            sipo_q      <= {WIDTH{1'b0}};
            in_cnt_q    <= CNT_ZERO;
            hold_q      <= {WIDTH{1'b0}};
            hold_full_q <= 1'b0;
            piso_q      <= {WIDTH{1'b0}};
            out_cnt_q   <= CNT_ZERO;
            piso_busy_q <= 1'b0;
        end else begin
            sipo_q      <= sipo_d;
            in_cnt_q    <= in_cnt_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            piso_q      <= piso_d;
            out_cnt_q   <= out_cnt_d;
            piso_busy_q <= piso_busy_d;
        end
    end

    // Output drive. d_out is forced low while idle so the line never shows
    // stale shift-register contents.
    assign sio.ready_o = ready_s;
    assign sio.valid_o = piso_busy_q;
    assign sio.d_out   = piso_busy_q ? piso_q[0] : 1'b0;

endmodule

// File: tb/tb_serdes_sipo_piso.sv
// -----------------------------------------------------------------------------
// tb_serdes_sipo_piso
// Self-checking bench for serdes_sipo_piso. Every accepted input bit is pushed
// into a scoreboard queue. Every output transfer pops and compares. Directed
// checks cover reset values, first-bit latency, no-bubble streaming,
// backpressure stalls, random gaps and reset in mid-operation.
// -----------------------------------------------------------------------------
module tb_serdes_sipo_piso;

    logic sclk = 1'b0;
    logic rst_i;

    always #5 sclk = ~sclk;

    serdes_sipo_piso_if sio();

    serdes_sipo_piso #(.WIDTH(8)) dut (
        .sclk_i (sclk),
        .rst_i  (rst_i),
        .sio    (sio)
    );

    int   n_checks    = 0;
    int   n_fail      = 0;
    logic exp_q[$];
    logic rand_rdy    = 1'b0;
    logic stream_on   = 1'b0;
    logic stream_seen = 1'b0;
    int   bubbles     = 0;
    int   stalls      = 0;

    // Single comparison point: counts and reports mismatches
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard monitor, sampled on the falling edge (inputs are stable there)
    always @(negedge sclk) begin
        if (rst_i) begin
            exp_q.delete();
        end else begin
            if (sio.valid_o && sio.ready_i) begin
                if (exp_q.size() == 0) begin
                    check_eq("sb_unexpected_out", 32'd1, 32'd0);
                end else begin
                    check_eq("sb_bit", {31'd0, sio.d_out}, {31'd0, exp_q.pop_front()});
                end
            end
            if (sio.valid_i && sio.ready_o) begin
                exp_q.push_back(sio.d_in);
            end
            if (stream_on) begin
                if (sio.valid_o) begin
                    stream_seen = 1'b1;
                end else if (stream_seen && exp_q.size() > 0) begin
                    bubbles++;
                end
            end
        end
    end

    // Advance one cycle and land 1 time unit after the rising edge
    task automatic tick();
        @(posedge sclk);
        #1;
        if (rand_rdy) sio.ready_i = 1'($urandom_range(0, 1));
    endtask

    // Present one bit and hold it until accepted (bounded)
    task automatic send_bit(input logic b);
        logic acc;
        int   guard;
        acc   = 1'b0;
        guard = 0;
        sio.d_in    = b;
        sio.valid_i = 1'b1;
        while (!acc && guard < 200) begin
            @(negedge sclk);
            acc = sio.ready_o;
            if (!acc) stalls++;
            tick();
            guard++;
        end
        if (!acc) check_eq("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_word(input logic [7:0] w);
        for (int i = 0; i < 8; i++) send_bit(w[i]);
    endtask

    // Let everything in flight emerge, then confirm nothing was left behind
    task automatic drain();
        int g;
        g = 0;
        sio.valid_i = 1'b0;
        rand_rdy    = 1'b0;
        sio.ready_i = 1'b1;
        while ((exp_q.size() > 0 || sio.valid_o) && g < 500) begin
            tick();
            g++;
        end
        check_eq("drain_empty", exp_q.size(), 32'd0);
        check_eq("drain_idle", {31'd0, sio.valid_o}, 32'd0);
    endtask

    // Hard stop if something hangs
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Main stimulus
    initial begin
        logic [7:0] w0, w1, w2;
        sio.d_in    = 1'b0;
        sio.valid_i = 1'b0;
        sio.ready_i = 1'b0;
        rst_i       = 1'b1;
        tick();
        tick();
        check_eq("rst_valid_o", {31'd0, sio.valid_o}, 32'd0);
        check_eq("rst_d_out",   {31'd0, sio.d_out},   32'd0);
        check_eq("rst_ready_o", {31'd0, sio.ready_o}, 32'd1);
        rst_i = 1'b0;
        repeat (3) tick();
        check_eq("idle_valid_o", {31'd0, sio.valid_o}, 32'd0);
        check_eq("idle_d_out",   {31'd0, sio.d_out},   32'd0);
        check_eq("idle_ready_o", {31'd0, sio.ready_o}, 32'd1);

        // Single word: valid_o rises one edge after the 8th accept
        sio.ready_i = 1'b1;
        send_word(8'b1011_0010);
        check_eq("single_pre_valid", {31'd0, sio.valid_o}, 32'd0);
        sio.valid_i = 1'b0;
        tick();
        check_eq("single_valid_rise", {31'd0, sio.valid_o}, 32'd1);
        check_eq("single_first_bit",  {31'd0, sio.d_out},   32'd0);
        repeat (8) tick();
        check_eq("single_valid_fall", {31'd0, sio.valid_o}, 32'd0);
        drain();

        // Streaming: 10 words, no stalls, no output bubbles
        stalls      = 0;
        bubbles     = 0;
        stream_seen = 1'b0;
        stream_on   = 1'b1;
        sio.ready_i = 1'b1;
        for (int k = 0; k < 10; k++) send_word(8'($urandom));
        drain();
        stream_on = 1'b0;
        check_eq("stream_stalls",  stalls,  32'd0);
        check_eq("stream_bubbles", bubbles, 32'd0);

        // Backpressure: two words fill PISO and hold, the third stalls at bit 7
        w0 = 8'($urandom);
        w1 = 8'($urandom);
        w2 = 8'($urandom);
        sio.ready_i = 1'b0;
        send_word(w0);
        send_word(w1);
        for (int i = 0; i < 7; i++) send_bit(w2[i]);
        sio.valid_i = 1'b0;
        check_eq("bp_ready_low", {31'd0, sio.ready_o}, 32'd0);
        check_eq("bp_valid_o",   {31'd0, sio.valid_o}, 32'd1);
        sio.d_in    = w2[7];
        sio.valid_i = 1'b1;
        repeat (3) begin
            tick();
            check_eq("bp_ready_hold", {31'd0, sio.ready_o}, 32'd0);
            check_eq("bp_valid_hold", {31'd0, sio.valid_o}, 32'd1);
            check_eq("bp_dout_hold",  {31'd0, sio.d_out},   {31'd0, w0[0]});
        end
        sio.ready_i = 1'b1;
        send_bit(w2[7]);
        drain();

        // Random input gaps and random output backpressure
        rand_rdy = 1'b1;
        for (int k = 0; k < 6; k++) begin
            w0 = 8'($urandom);
            for (int i = 0; i < 8; i++) begin
                sio.valid_i = 1'b0;
                repeat ($urandom_range(0, 2)) tick();
                send_bit(w0[i]);
            end
        end
        drain();

        // Reset with a partial input word and a word mid-serialisation
        sio.ready_i = 1'b1;
        send_word(8'($urandom));
        w1 = 8'($urandom);
        for (int i = 0; i < 5; i++) send_bit(w1[i]);
        check_eq("mid_valid_before_rst", {31'd0, sio.valid_o}, 32'd1);
        sio.valid_i = 1'b0;
        rst_i       = 1'b1;
        tick();
        check_eq("mid_rst_valid_o", {31'd0, sio.valid_o}, 32'd0);
        check_eq("mid_rst_d_out",   {31'd0, sio.d_out},   32'd0);
        check_eq("mid_rst_ready_o", {31'd0, sio.ready_o}, 32'd1);
        rst_i = 1'b0;
        send_word(8'($urandom));
        drain();

        check_eq("final_queue_empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
